// File: rtl/uart_rx_if.sv
// uart_rx_if -- byte delivery bus between the UART receiver and its consumer.
//
// Signals:
//   data_o       [7:0] received byte, meaningful only while valid_o is high
//   valid_o            a byte is held for the consumer
//   ready_i            consumer can take the byte
//   frame_err_o        one-cycle pulse: stop bit was sampled low
//   overrun_o          one-cycle pulse: a byte completed while the holder was full
//
// Handshake: a byte moves on any rising clock edge where valid_o && ready_i.
// The source keeps valid_o and data_o stable until that edge. ready_i may be
// held high permanently, in which case valid_o degenerates to a one-cycle
// pulse per byte.
//
// Modports: master = the receiver (drives data/valid/pulses),
//           slave  = the consumer (drives ready_i).
interface uart_rx_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;

  modport master (
    output data_o,
    output valid_o,
    output frame_err_o,
    output overrun_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    input  frame_err_o,
    input  overrun_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with a single-entry valid/ready holding register.
//
// The asynchronous rx_i line is brought into the clock domain by a two-flop
// synchroniser. A start bit is qualified at its centre, the eight data bits
// are sampled at their centres LSB-first, and the stop bit is checked. Good
// bytes go to the holding register; bad stop bits raise frame_err_o.
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_i        asynchronous active-high reset
//   rx_i         serial line, idle high, asynchronous to clk_i
//   rx_bus       uart_rx_if.master: data_o, valid_o, ready_i, frame_err_o, overrun_o
//   busy_o       high whenever the receiver FSM is not idle
//   state_dbg_o  current FSM state (debug visibility)
//
// Parameters: CLK_FREQ (Hz), BAUD (bit/s). CLKS_PER_BIT must be at least 8.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  uart_rx_if.master  rx_bus,
  output logic       busy_o,
  output logic [2:0] state_dbg_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 8) begin : g_bad_cfg
    $fatal(1, "uart_rx: CLKS_PER_BIT=%0d is below the minimum of 8", CLKS_PER_BIT);
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  // Synchroniser flops; reset high so that reset never looks like a start bit.
  logic rx_meta_q, rx_s_q;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          deliver;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      // Re-check the line at the start-bit centre so short glitches are ignored.
      START: begin
        if (cnt_q == CNT_HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Counting a full bit period from the start-bit centre lands on each
      // data-bit centre.
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shreg_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // A held-low line (break) must return high before a new frame can start.
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Holding register. A delivery that meets a same-edge acceptance refills
    // the register without a gap; a delivery into a full, unaccepted
    // register is dropped and flagged.
    if (deliver) begin
      if (!valid_q || rx_bus.ready_i) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_bus.ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign rx_bus.data_o      = data_q;
  assign rx_bus.valid_o     = valid_q;
  assign rx_bus.frame_err_o = frame_err_q;
  assign rx_bus.overrun_o   = overrun_q;
  assign busy_o             = (state_q != IDLE);
  assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx at 100 MHz / 1 Mbaud
// (100 clocks per bit). Frames are generated at the line level; the expected
// byte stream is the list of well-formed frames sent with ready held high.
module tb_uart_rx;

  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       busy;
  logic [2:0] state_dbg;

  uart_rx_if bus();

  uart_rx #(
    .CLK_FREQ(100_000_000),
    .BAUD    (1_000_000)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_i       (rx),
    .rx_bus     (bus),
    .busy_o     (busy),
    .state_dbg_o(state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         v_rises   = 0;
  int         fe_cnt    = 0;
  int         ov_cnt    = 0;
  logic       valid_prev = 1'b0;
  longint     last_rise = 0;
  longint     start_cyc = 0;

  // Output monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (bus.valid_o && !valid_prev) begin
      v_rises   = v_rises + 1;
      last_rise = cyc;
    end
    valid_prev = bus.valid_o;
    if (bus.valid_o && bus.ready_i) got_q.push_back(bus.data_o);
    if (bus.frame_err_o) fe_cnt = fe_cnt + 1;
    if (bus.overrun_o)   ov_cnt = ov_cnt + 1;
  end

  // ---------------- driver ----------------
  // One 8N1 frame, each bit held for bit_cyc clocks. The line is left at the
  // stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_cyc);
    @(negedge clk);
    rx        = 1'b0;
    start_cyc = cyc;
    repeat (bit_cyc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bit_cyc) @(negedge clk);
    end
    rx = stop_bit;
    repeat (bit_cyc) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int v0, fe0, ov0;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
    checks++; if (bus.data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data_o); end
    checks++; if (bus.frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err_o); end
    checks++; if (bus.overrun_o !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", bus.overrun_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    v0 = v_rises; fe0 = fe_cnt; ov0 = ov_cnt;
    repeat (2000) @(negedge clk);
    checks++; if (v_rises - v0 !== 0) begin errors++; $display("FAIL idle_valid: got %0d pulses want 0", v_rises - v0); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL idle_ferr: got %0d pulses want 0", fe_cnt - fe0); end
    checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL idle_ovr: got %0d pulses want 0", ov_cnt - ov0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_bytes;
    logic [7:0] pats[4];
    logic [7:0] g;
    int v0;
    longint lat;
    pats = '{8'h55, 8'hA3, 8'h00, 8'hFF};
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got_q.delete();
      v0 = v_rises;
      send_frame(pats[i], 1'b1, CPB);
      repeat (20) @(negedge clk);
      g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
      checks++; if (v_rises - v0 !== 1) begin errors++; $display("FAIL single_pulses[%0h]: got %0d want 1", pats[i], v_rises - v0); end
      checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count[%0h]: got %0d want 1", pats[i], got_q.size()); end
      checks++; if (g !== pats[i]) begin errors++; $display("FAIL single_data: got %h want %h", g, pats[i]); end
      // Start edge is the posedge following the falling line.
      lat = last_rise - (start_cyc + 1);
      checks++; if (lat < 951 || lat > 953) begin errors++; $display("FAIL single_latency[%0h]: got %0d want 952+-1", pats[i], lat); end
    end
  endtask

  task automatic test_glitch;
    int v0, fe0;
    v0 = v_rises; fe0 = fe_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_mid: got %b want 1", busy); end
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
    checks++; if (v_rises - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", v_rises - v0); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_err;
    int v0, fe0;
    logic [7:0] g;
    v0 = v_rises; fe0 = fe_cnt;
    got_q.delete();
    send_frame(8'h3C, 1'b0, CPB);
    repeat (500) @(negedge clk);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - fe0); end
    checks++; if (v_rises - v0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d want 0", v_rises - v0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_break_busy: got %b want 1", busy); end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_recover_busy: got %b want 0", busy); end
    send_frame(8'h81, 1'b1, CPB);
    repeat (20) @(negedge clk);
    g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d want 1", got_q.size()); end
    checks++; if (g !== 8'h81) begin errors++; $display("FAIL ferr_next_data: got %h want 81", g); end
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_next_pulses: got %0d want 1", fe_cnt - fe0); end
  endtask

  task automatic test_overrun;
    int ov0;
    ov0 = ov_cnt;
    bus.ready_i = 1'b0;
    send_frame(8'h12, 1'b1, CPB);
    send_frame(8'h34, 1'b1, CPB);
    repeat (60) @(negedge clk);
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b want 1", bus.valid_o); end
    checks++; if (bus.data_o !== 8'h12) begin errors++; $display("FAIL ovr_data_held: got %h want 12", bus.data_o); end
    checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", ov_cnt - ov0); end
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL ovr_accept_valid: got %b want 0", bus.valid_o); end
    checks++; if (bus.data_o !== 8'h12) begin errors++; $display("FAIL ovr_accept_data: got %h want 12", bus.data_o); end
    got_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    logic [7:0] g;
    bus.ready_i = 1'b1;
    got_q.delete();
    v0 = v_rises;
    fork
      send_frame(8'hC6, 1'b1, CPB);
      begin
        // Middle of data bit 4.
        repeat (551) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (bus.data_o !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", bus.data_o); end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", bus.valid_o); end
        checks++; if (bus.frame_err_o !== 1'b0 || bus.overrun_o !== 1'b0) begin
          errors++; $display("FAIL rstmid_pulses: got ferr=%b ovr=%b want 0 0", bus.frame_err_o, bus.overrun_o);
        end
      end
    join
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(8'h5A, 1'b1, CPB);
    repeat (20) @(negedge clk);
    g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    checks++; if (v_rises - v0 !== 1) begin errors++; $display("FAIL rstmid_pulses_total: got %0d want 1", v_rises - v0); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", got_q.size()); end
    checks++; if (g !== 8'h5A) begin errors++; $display("FAIL rstmid_data_after: got %h want 5a", g); end
  endtask

  // Random bytes, random inter-frame gaps (including zero) and bit periods
  // within +-2% of nominal; every frame is well formed, so every byte must
  // come out in order.
  task automatic test_back_to_back;
    int fe0, ov0, bc, gap;
    logic [7:0] b, g;
    fe0 = fe_cnt; ov0 = ov_cnt;
    bus.ready_i = 1'b1;
    got_q.delete();
    exp_q.delete();
    for (int n = 0; n < 12; n++) begin
      b   = 8'($urandom_range(0, 255));
      bc  = int'($urandom_range(98, 102));
      gap = (n % 3 == 0) ? 0 : int'($urandom_range(0, 150));
      send_frame(b, 1'b1, bc);
      exp_q.push_back(b);
      repeat (gap) @(negedge clk);
    end
    repeat (100) @(negedge clk);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks++; if (g !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, g, exp_q[i]); end
    end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d want 0", fe_cnt - fe0); end
    checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL b2b_ovr: got %0d want 0", ov_cnt - ov0); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    bus.ready_i = 1'b1;
    test_reset();
    test_single_bytes();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver, the receive-side counterpart of `uart_tx`, sharing its `CLK_FREQ`/`BAUD` parameterisation. It synchronises the asynchronous `rx_i` line and detects the start bit, centre-samples eight data bits LSB-first, and checks the stop bit. Each received byte is presented on a single-entry valid/ready output register to the SoC UART peripheral, with one-cycle pulses for framing errors and overruns.

## Interface

Parameters:
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115_200: line rate in bit/s.
- Derived constants:
  - `CLKS_PER_BIT = CLK_FREQ / BAUD`, integer division.
  - `HALF = CLKS_PER_BIT / 2`.
  - Elaboration fatal error if `CLKS_PER_BIT < 8`.

Ports:
- `clk_i` in 1: single clock; all logic on its rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `rx_i` in 1: serial line, idle high, asynchronous to `clk_i`.
- `data_o` out 8: received byte, valid while `valid_o`=1.
- `valid_o` out 1: byte available; held until accepted.
- `ready_i` in 1: consumer accepts `data_o` when `valid_o && ready_i` at a clock edge.
- `frame_err_o` out 1: one-cycle pulse, stop bit sampled low.
- `overrun_o` out 1: one-cycle pulse, byte completed while the holding register was full.
- `busy_o` out 1: high whenever the FSM is not in IDLE.

## Operation

Input synchroniser:
- Two-flop synchroniser `rx_i` -> `rx_s`; both flops reset to 1.
- The FSM uses only `rx_s`.

FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. A clock counter `cnt`, of width `$clog2(CLKS_PER_BIT)`, and a 3-bit bit index `idx` drive the sampling.
- **IDLE**: on `rx_s`=0, go to START with `cnt`=0.
- **START**: count up.
  - At `cnt`==`HALF-1`, sample `rx_s`.
  - If 0: go to DATA with `cnt`=0, `idx`=0.
  - If 1: glitch; return to IDLE with no pulse.
- **DATA**: count up.
  - At `cnt`==`CLKS_PER_BIT-1`, shift `rx_s` into `shreg[idx]` (LSB first) and set `cnt`=0.
  - After `idx`==7, go to STOP; otherwise increment `idx`.
- **STOP**: at `cnt`==`CLKS_PER_BIT-1`, sample `rx_s`.
  - If 1: deliver the byte (see Output register) and go to IDLE.
  - If 0: pulse `frame_err_o`, discard the byte, and go to WAIT_IDLE.
- **WAIT_IDLE**: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from retriggering reception.

Output register:
- Delivering a byte with `valid_o`=0: load `data_o`=`shreg` and set `valid_o`=1.
- Delivering a byte with `valid_o`=1 and `ready_i`=0 on the same edge: pulse `overrun_o`, drop the new byte, and keep the old `data_o`.
- Delivery coinciding with `valid_o && ready_i`: load the new byte, `valid_o` stays 1, no overrun.
- `valid_o && ready_i` without delivery: clear `valid_o`; `data_o` is unchanged.
- Framing-error frames never touch `data_o` or `valid_o`.

## Timing

Reset values:
- `valid_o`=0, `data_o`=0x00, `frame_err_o`=0, `overrun_o`=0, `busy_o`=0.
- FSM in IDLE; synchroniser flops at 1.

Reset asserted mid-frame:
- Immediately (asynchronously) returns the FSM to IDLE and sets every output to its reset value.
- The partial byte is lost.

Frame timing, with E = the first edge at which `rx_i`=0 meets setup:
- `rx_s`=0 from E+1; the FSM enters START at edge E+2.
- Start sample at edge E+2+`HALF`.
- Data bit i sampled at edge E+2+`HALF`+(i+1)·`CLKS_PER_BIT`.
- Stop bit sampled at edge E+2+`HALF`+9·`CLKS_PER_BIT`; `valid_o` / `frame_err_o` / `overrun_o` are registered at that edge.

Back-to-back frames:
- A new start bit is accepted the cycle after returning to IDLE. This covers zero-gap frames, since the stop-bit centre leaves half a bit of margin.

Tolerance: frames are received correctly with up to ±2% baud mismatch.

Acceptance: `ready_i` may be held high permanently; `valid_o` is then a one-cycle pulse per byte.

## Test plan

All scenarios use `CLK_FREQ`=100 MHz and `BAUD`=1 MHz, so `CLKS_PER_BIT`=100.

- **Reset/idle**: reset, then hold `rx_i`=1 for 2000 cycles -> `valid_o`=0, `busy_o`=0, no error pulses.
- **Single bytes**: drive the 0x55, 0xA3, 0x00 and 0xFF frames with `ready_i`=1.
  - Each gives exactly one `valid_o` pulse with the matching `data_o`.
  - `valid_o` rises 952±1 cycles after the start edge.
- **Glitch**: pulse `rx_i` low for 20 cycles -> FSM returns to IDLE, no `valid_o`, no `frame_err_o`.
- **Framing error**: send 0x3C with the stop bit low, then hold low for 500 cycles, then high, then send 0x81.
  - One `frame_err_o` pulse for the 0x3C frame, no `valid_o`.
  - 0x81 is then received correctly.
- **Overrun/backpressure**: `ready_i`=0; send 0x12 then 0x34 back-to-back.
  - `data_o`=0x12 is held and `overrun_o` pulses once at the second stop sample.
  - Raising `ready_i` clears `valid_o`.
- **Reset mid-frame**: assert `rst_i` during data bit 4 of 0xC6, release it, then send 0x5A.
  - All outputs go to 0 immediately.
  - Only 0x5A is delivered.
